mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer sitting directly upstream of the 256x16 multi-cycle data/instruction memory.
- Accepts independent requests from the instruction-fetch port (read-only) and the data port (read/write).
- Serialises the requests onto the memory's single start/ready handshake, latches the returned word, and returns it to the winning requester with a one-cycle ack.

Parameters:
- ADDR_W, 8, address width of both ports and the memory.
- DATA_W, 16, data word width.
- RR_EN, 0: 0 = fixed priority, data port wins; 1 = round-robin, the port not served last wins a tie.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; valid from the if_ack cycle, held until the next fetch completes.
- if_ack  out  1  one-cycle completion pulse for the fetch port.
- d_req  in  1  data request; held high until d_ack.
- d_rwn  in  1  1 = read, 0 = write.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data; held until the next data read completes.
- d_ack  out  1  one-cycle completion pulse for the data port.
- mem_start  out  1  memory start strobe.
- mem_rwn  out  1  memory read/write-not.
- mem_address  out  ADDR_W  memory address.
- mem_data_in  out  DATA_W  memory write data.
- mem_data_out  in  DATA_W  memory read data.
- mem_ready  in  1  memory idle; goes low the cycle after the memory accepts a start, and returns high when the access completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: state IDLE; mem_start 0; mem_rwn 1; mem_address 0; mem_data_in 0; if_ack 0; d_ack 0; if_rdata 0; d_rdata 0; round-robin pointer favours the data port.
- Reset asserted mid-transaction: abort immediately to the reset values. No ack is issued for the aborted access. The memory shares this reset.
- IDLE:
  - At a posedge with any req high, select a winner: fixed mode picks data over fetch; round-robin mode picks the port not granted last.
  - Latch the winner's addr/rwn/wdata into the mem_* output registers. Fetch forces mem_rwn=1.
  - Set mem_start=1 and go to ISSUE.
  - A request is granted only if its req is sampled high in IDLE.
- ISSUE:
  - mem_start held at 1.
  - At a posedge with mem_ready=1 the memory accepts: clear mem_start and go to WAIT.
  - If mem_ready=0, stay in ISSUE with mem_start held.
- WAIT:
  - Ignore mem_ready for the first WAIT cycle, since the memory status has not yet updated.
  - At any later posedge with mem_ready=1: for a read, capture mem_data_out into the winner's rdata register. Assert the winner's ack and go to DONE.
- DONE:
  - ack high for exactly this one cycle, then return to IDLE.
  - The requester drops req at the edge leaving DONE, so the following IDLE sample cannot re-grant the same request.
- Latency: memory busy time is k+1 cycles, where k = mem_address[1:0].
  - A request sampled at edge E0 raises ack at edge E0+k+3 and drops it at E0+k+4.
  - The earliest next grant is at E0+k+5.
- Writes: d_rdata is unchanged and d_ack still pulses.
- Dropped request: if req drops before ack, the latched transaction still completes and ack still pulses.
- Both reqs high: exactly one is granted. The loser stays pending and is granted at the next IDLE sample.
- Round-robin mode: the pointer updates at every grant to "other port".
- The mem_* outputs hold their last values outside ISSUE/WAIT; only mem_start carries meaning.

Test Plan:
- Memory at reset contents; fetch addr 0 at E0 → mem_start high one accepted cycle; if_ack at E0+3; if_rdata=0x698C.
- Data read addr 249 (k=1) → d_ack at E0+4; d_rdata=0x0005. Data read addr 245 (k=1) → d_rdata=0x0008.
- Data write addr 250 data 0xBEEF, then data read addr 250 → second d_ack with d_rdata=0xBEEF. d_rdata does not change on the write ack.
- RR_EN=0, both reqs high continuously (fetch 0, data 249) → data served first, then fetch. RR_EN=1 with repeated requests → grants alternate data, fetch, data.
- Reset asserted while in WAIT on read addr 3 → all outputs return to reset values at once, no ack. After release, a fresh fetch of addr 2 returns 0x694A.
- Requester holds req one extra cycle past ack → no duplicate grant; only one mem_start observed.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter that serialises requests onto a single
// multi-cycle memory start/ready handshake and returns the word with a one-cycle ack.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter bit          RR_EN  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_rwn,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_start,
  output logic              mem_rwn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_grant_d;
  logic                r_rr_data;
  logic                r_first_wait;
  logic                r_mem_start;
  logic                r_mem_rwn;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_data_in;
  logic                r_if_ack;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  // Data wins unless round-robin is enabled and the fetch port is favoured.
  logic w_pick_d;
  assign w_pick_d = d_req && (!if_req || !RR_EN || r_rr_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant_d     <= 1'b0;
      r_rr_data     <= 1'b1;
      r_first_wait  <= 1'b0;
      r_mem_start   <= 1'b0;
      r_mem_rwn     <= 1'b1;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_if_ack      <= 1'b0;
      r_d_ack       <= 1'b0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_req || d_req) begin
            r_grant_d   <= w_pick_d;
            r_rr_data   <= !w_pick_d;
            r_mem_start <= 1'b1;
            r_state     <= ISSUE;
            if (w_pick_d) begin
              r_mem_rwn     <= d_rwn;
              r_mem_address <= d_addr;
              r_mem_data_in <= d_wdata;
            end else begin
              r_mem_rwn     <= 1'b1;
              r_mem_address <= if_addr;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            r_mem_start  <= 1'b0;
            r_first_wait <= 1'b1;
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          // Memory ready is stale on the first WAIT cycle, so it is skipped.
          r_first_wait <= 1'b0;
          if (!r_first_wait && mem_ready) begin
            if (r_grant_d) begin
              r_d_ack <= 1'b1;
              if (r_mem_rwn) r_d_rdata <= mem_data_out;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= mem_data_out;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata    = r_if_rdata;
  assign if_ack      = r_if_ack;
  assign d_rdata     = r_d_rdata;
  assign d_ack       = r_d_ack;
  assign mem_start   = r_mem_start;
  assign mem_rwn     = r_mem_rwn;
  assign mem_address = r_mem_address;
  assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 fixed priority, instance 1 round-robin,
// each attached to a behavioural multi-cycle 256x16 memory.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req       [2];
  logic [7:0]  if_addr      [2];
  logic [15:0] if_rdata     [2];
  logic        if_ack       [2];
  logic        d_req        [2];
  logic        d_rwn        [2];
  logic [7:0]  d_addr       [2];
  logic [15:0] d_wdata      [2];
  logic [15:0] d_rdata      [2];
  logic        d_ack        [2];
  logic        mem_start    [2];
  logic        mem_rwn      [2];
  logic [7:0]  mem_address  [2];
  logic [15:0] mem_data_in  [2];
  logic [15:0] mem_data_out [2];
  logic        mem_ready    [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'd0:    return 16'h698C;
      8'd2:    return 16'h694A;
      8'd245:  return 16'h0008;
      8'd249:  return 16'h0005;
      default: return {8'hA5, a};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gu
    mem_arbiter #(.ADDR_W(8), .DATA_W(16), .RR_EN(g == 1)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
      .d_req(d_req[g]), .d_rwn(d_rwn[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
      .mem_start(mem_start[g]), .mem_rwn(mem_rwn[g]), .mem_address(mem_address[g]),
      .mem_data_in(mem_data_in[g]), .mem_data_out(mem_data_out[g]), .mem_ready(mem_ready[g])
    );

    logic [15:0] mem [256];
    logic        rdy;
    logic [1:0]  cnt;
    logic [7:0]  la;
    logic        lrwn;
    logic [15:0] lwd;
    logic [15:0] dout;
    int          acc_cnt = 0;

    // Busy for k+1 cycles after accepting a start, k = address[1:0].
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        rdy  <= 1'b1;
        cnt  <= 2'd0;
        dout <= 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      end else if (rdy) begin
        if (mem_start[g]) begin
          rdy     <= 1'b0;
          cnt     <= mem_address[g][1:0];
          la      <= mem_address[g];
          lrwn    <= mem_rwn[g];
          lwd     <= mem_data_in[g];
          acc_cnt <= acc_cnt + 1;
        end
      end else if (cnt == 2'd0) begin
        rdy <= 1'b1;
        if (lrwn) dout <= mem[la];
        else      mem[la] <= lwd;
      end else begin
        cnt <= cnt - 2'd1;
      end
    end

    assign mem_ready[g]    = rdy;
    assign mem_data_out[g] = dout;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction; lat = edges from the grant-sampling edge to the ack edge, -1 on timeout.
  task automatic do_xfer(input int u, input bit is_d, input bit rwn, input logic [7:0] addr,
                         input logic [15:0] wd, output int lat);
    if (is_d) begin
      d_req[u] = 1'b1; d_rwn[u] = rwn; d_addr[u] = addr; d_wdata[u] = wd;
    end else begin
      if_req[u] = 1'b1; if_addr[u] = addr;
    end
    lat = -1;
    for (int n = 0; n < 30; n++) begin
      tick();
      if ((is_d && d_ack[u]) || (!is_d && if_ack[u])) begin
        lat = n;
        break;
      end
    end
    d_req[u]  = 1'b0;
    if_req[u] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      checks += 6;
      if (mem_start[u] !== 1'b0) begin errors++; $display("FAIL reset_mem_start[%0d] got %b exp 0", u, mem_start[u]); end
      if (mem_rwn[u] !== 1'b1) begin errors++; $display("FAIL reset_mem_rwn[%0d] got %b exp 1", u, mem_rwn[u]); end
      if (mem_address[u] !== 8'h00) begin errors++; $display("FAIL reset_mem_address[%0d] got %h exp 00", u, mem_address[u]); end
      if (mem_data_in[u] !== 16'h0000) begin errors++; $display("FAIL reset_mem_data_in[%0d] got %h exp 0000", u, mem_data_in[u]); end
      if ({if_ack[u], d_ack[u]} !== 2'b00) begin errors++; $display("FAIL reset_acks[%0d] got %b exp 00", u, {if_ack[u], d_ack[u]}); end
      if ({if_rdata[u], d_rdata[u]} !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d] got %h exp 0", u, {if_rdata[u], d_rdata[u]}); end
    end
  endtask

  task automatic test_fetch();
    int lat;
    int a0;
    a0 = gu[0].acc_cnt;
    do_xfer(0, 1'b0, 1'b1, 8'd0, 16'h0000, lat);
    checks += 4;
    if (lat !== 3) begin errors++; $display("FAIL fetch_latency got %0d exp 3", lat); end
    if (if_rdata[0] !== 16'h698C) begin errors++; $display("FAIL fetch_rdata got %h exp 698C", if_rdata[0]); end
    if (gu[0].acc_cnt - a0 !== 1) begin errors++; $display("FAIL fetch_starts got %0d exp 1", gu[0].acc_cnt - a0); end
    if (if_ack[0] !== 1'b0) begin errors++; $display("FAIL fetch_ack_pulse got %b exp 0", if_ack[0]); end
  endtask

  task automatic test_data_read();
    int lat;
    do_xfer(0, 1'b1, 1'b1, 8'd249, 16'h1234, lat);
    checks += 2;
    if (lat !== 4) begin errors++; $display("FAIL dread249_latency got %0d exp 4", lat); end
    if (d_rdata[0] !== 16'h0005) begin errors++; $display("FAIL dread249_rdata got %h exp 0005", d_rdata[0]); end
    do_xfer(0, 1'b1, 1'b1, 8'd245, 16'h1234, lat);
    checks += 2;
    if (lat !== 4) begin errors++; $display("FAIL dread245_latency got %0d exp 4", lat); end
    if (d_rdata[0] !== 16'h0008) begin errors++; $display("FAIL dread245_rdata got %h exp 0008", d_rdata[0]); end
  endtask

  task automatic test_write_read();
    int lat;
    do_xfer(0, 1'b1, 1'b0, 8'd250, 16'hBEEF, lat);
    checks += 3;
    if (lat !== 5) begin errors++; $display("FAIL write_latency got %0d exp 5", lat); end
    if (d_rdata[0] !== 16'h0008) begin errors++; $display("FAIL write_rdata_held got %h exp 0008", d_rdata[0]); end
    if (mem_rwn[0] !== 1'b0) begin errors++; $display("FAIL write_mem_rwn got %b exp 0", mem_rwn[0]); end
    do_xfer(0, 1'b1, 1'b1, 8'd250, 16'h0000, lat);
    checks += 3;
    if (lat !== 5) begin errors++; $display("FAIL readback_latency got %0d exp 5", lat); end
    if (d_rdata[0] !== 16'hBEEF) begin errors++; $display("FAIL readback_rdata got %h exp BEEF", d_rdata[0]); end
    if (if_rdata[0] !== 16'h698C) begin errors++; $display("FAIL readback_if_rdata_held got %h exp 698C", if_rdata[0]); end
  endtask

  task automatic test_both_fixed();
    int td = -1;
    int tf = -1;
    if_req[0] = 1'b1; if_addr[0] = 8'd0;
    d_req[0] = 1'b1; d_rwn[0] = 1'b1; d_addr[0] = 8'd249; d_wdata[0] = 16'h1234;
    for (int n = 0; n < 30 && tf < 0; n++) begin
      tick();
      if (d_ack[0]) begin td = n; d_req[0] = 1'b0; end
      if (if_ack[0]) begin tf = n; if_req[0] = 1'b0; end
    end
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    tick();
    checks += 4;
    if (td !== 4) begin errors++; $display("FAIL fixed_data_first_ack got %0d exp 4", td); end
    if (tf !== 9) begin errors++; $display("FAIL fixed_fetch_second_ack got %0d exp 9", tf); end
    if (d_rdata[0] !== 16'h0005) begin errors++; $display("FAIL fixed_d_rdata got %h exp 0005", d_rdata[0]); end
    if (if_rdata[0] !== 16'h698C) begin errors++; $display("FAIL fixed_if_rdata got %h exp 698C", if_rdata[0]); end
  endtask

  task automatic test_rr();
    int at [3];
    bit ap [3];
    int na = 0;
    bit rd = 0;
    bit rf = 0;
    for (int i = 0; i < 3; i++) begin at[i] = -1; ap[i] = 1'b0; end
    if_req[1] = 1'b1; if_addr[1] = 8'd0;
    d_req[1] = 1'b1; d_rwn[1] = 1'b1; d_addr[1] = 8'd249; d_wdata[1] = 16'h0000;
    for (int n = 0; n < 40 && na < 3; n++) begin
      tick();
      if (rd) begin d_req[1] = 1'b1; rd = 0; end
      if (rf) begin if_req[1] = 1'b1; rf = 0; end
      if (d_ack[1]) begin at[na] = n; ap[na] = 1'b1; na++; d_req[1] = 1'b0; rd = 1; end
      if (if_ack[1] && na < 3) begin at[na] = n; ap[na] = 1'b0; na++; if_req[1] = 1'b0; rf = 1; end
    end
    d_req[1] = 1'b0; if_req[1] = 1'b0;
    tick();
    checks += 5;
    if (na !== 3) begin errors++; $display("FAIL rr_ack_count got %0d exp 3", na); end
    if ({ap[0], ap[1], ap[2]} !== 3'b101) begin errors++; $display("FAIL rr_order got %b exp 101 (1=data)", {ap[0], ap[1], ap[2]}); end
    if (at[0] !== 4 || at[1] !== 9 || at[2] !== 15) begin
      errors++; $display("FAIL rr_ack_times got %0d,%0d,%0d exp 4,9,15", at[0], at[1], at[2]);
    end
    if (if_rdata[1] !== 16'h698C) begin errors++; $display("FAIL rr_if_rdata got %h exp 698C", if_rdata[1]); end
    if (d_rdata[1] !== 16'h0005) begin errors++; $display("FAIL rr_d_rdata got %h exp 0005", d_rdata[1]); end
  endtask

  task automatic test_reset_mid();
    int a0;
    int acks = 0;
    int lat;
    d_req[0] = 1'b1; d_rwn[0] = 1'b1; d_addr[0] = 8'd3; d_wdata[0] = 16'h1234;
    tick(); tick(); tick();
    checks += 1;
    if (mem_address[0] !== 8'd3 || mem_start[0] !== 1'b0 || mem_ready[0] !== 1'b0) begin
      errors++; $display("FAIL midreset_setup got addr %h start %b ready %b exp 03 0 0", mem_address[0], mem_start[0], mem_ready[0]);
    end
    reset = 1'b1;
    #1;
    checks += 5;
    if (mem_start[0] !== 1'b0 || mem_rwn[0] !== 1'b1) begin errors++; $display("FAIL midreset_start_rwn got %b%b exp 01", mem_start[0], mem_rwn[0]); end
    if (mem_address[0] !== 8'h00) begin errors++; $display("FAIL midreset_address got %h exp 00", mem_address[0]); end
    if (mem_data_in[0] !== 16'h0000) begin errors++; $display("FAIL midreset_data_in got %h exp 0000", mem_data_in[0]); end
    if (d_rdata[0] !== 16'h0000 || if_rdata[0] !== 16'h0000) begin errors++; $display("FAIL midreset_rdata got %h %h exp 0000 0000", d_rdata[0], if_rdata[0]); end
    if (d_ack[0] !== 1'b0 || if_ack[0] !== 1'b0) begin errors++; $display("FAIL midreset_acks got %b%b exp 00", d_ack[0], if_ack[0]); end
    d_req[0] = 1'b0;
    tick(); tick();
    reset = 1'b0;
    a0 = gu[0].acc_cnt;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (d_ack[0] || if_ack[0]) acks++;
    end
    checks += 2;
    if (acks !== 0) begin errors++; $display("FAIL midreset_no_ack got %0d exp 0", acks); end
    if (gu[0].acc_cnt - a0 !== 0) begin errors++; $display("FAIL midreset_no_start got %0d exp 0", gu[0].acc_cnt - a0); end
    do_xfer(0, 1'b0, 1'b1, 8'd2, 16'h0000, lat);
    checks += 2;
    if (lat !== 5) begin errors++; $display("FAIL postreset_fetch_latency got %0d exp 5", lat); end
    if (if_rdata[0] !== 16'h694A) begin errors++; $display("FAIL postreset_fetch_rdata got %h exp 694A", if_rdata[0]); end
  endtask

  task automatic test_hold_extra();
    int a0;
    int lat = -1;
    int acks = 0;
    int starts = 0;
    a0 = gu[0].acc_cnt;
    if_req[0] = 1'b1; if_addr[0] = 8'd0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (if_ack[0]) begin lat = n; break; end
    end
    tick();
    if_req[0] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (if_ack[0]) acks++;
      if (mem_start[0]) starts++;
    end
    checks += 4;
    if (lat !== 3) begin errors++; $display("FAIL hold_latency got %0d exp 3", lat); end
    if (acks !== 0) begin errors++; $display("FAIL hold_dup_ack got %0d exp 0", acks); end
    if (starts !== 0) begin errors++; $display("FAIL hold_dup_start_cycles got %0d exp 0", starts); end
    if (gu[0].acc_cnt - a0 !== 1) begin errors++; $display("FAIL hold_starts got %0d exp 1", gu[0].acc_cnt - a0); end
  endtask

  initial begin
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      if_req[u] = 1'b0; if_addr[u] = 8'd0;
      d_req[u] = 1'b0; d_rwn[u] = 1'b1; d_addr[u] = 8'd0; d_wdata[u] = 16'h0000;
    end
    #2 reset = 1'b1;
    tick(); tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_fetch();
    test_data_read();
    test_write_read();
    test_both_fixed();
    test_rr();
    test_reset_mid();
    test_hold_extra();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
